io_led_driver: RTL and testbench
================================

# io_led_driver

Drives the active-low power/activity LED line, which is the LED input of the IO model. It takes the CIA-A LED request bit, an enable, and a drive-activity strobe, and produces one registered active-low LED output. Supported behaviours are full brightness, PWM dim and retriggerable activity flashes. It sits between the CIA port logic and the board/IO model LED pin.

## Interface
- PWM_BITS, 4: width of the free-running PWM counter. The dim period is 2^PWM_BITS cycles.
- DIM_DUTY, 4: number of lit cycles per PWM period in DIM. Range 0..2^PWM_BITS.
- BLINK_CYCLES, 16: number of cycles the LED is forced off per activity flash. 0 disables flashes.

- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  1 = LED function active; 0 = LED forced off.
- _LED_REQ  in  1  asynchronous, active-low brightness request (CIA PRA bit 1). 0 = full on, 1 = dim.
- ACT  in  1  asynchronous drive-activity level. Each rising edge starts or retriggers a flash.
- _O  out  1  registered, active-low LED drive. 0 = lit.
- STATE  out  2  current FSM state: OFF=0, DIM=1, ON=2, BLINK=3.

## Operation
- Input conditioning: _LED_REQ and ACT each pass through a 2-flop synchroniser.
  - Reset values: _LED_REQ stages 1, ACT stages 0.
  - Activity edge = synchronised ACT is 1 and its previous registered value was 0. The previous-value flop resets to 0.
- PWM counter: width PWM_BITS, resets to 0, increments every cycle, wraps from 2^PWM_BITS-1 to 0.
- Dim compare: pwm_cnt < DIM_DUTY, evaluated at PWM_BITS+1 bits.
  - DIM_DUTY=0 gives never lit.
  - DIM_DUTY=2^PWM_BITS gives always lit.
- Flash counter: width clog2(BLINK_CYCLES+1), resets to 0.
- FSM. Next-state priority, highest first:
  1. RESET: go to OFF.
  2. ENABLE=0: go to OFF from any state. This aborts BLINK and clears the flash counter.
  3. Activity edge while in DIM, ON or BLINK, with BLINK_CYCLES>0: go to BLINK and load the flash counter with BLINK_CYCLES. An edge during BLINK reloads the counter (retrigger).
  4. In BLINK: decrement the counter. When the counter is 1, leave BLINK at the next edge to the request state.
  5. Otherwise, go to the request state.
- Request state: ON if synchronised _LED_REQ=0, DIM if it is 1.
- Activity edges in OFF are ignored.
- _O next value by state:
  - OFF: 1.
  - ON: 0.
  - BLINK: 1.
  - DIM: 0 when the dim compare is true, else 1.
- STATE is the registered state encoding.

## Timing
- Reset values: _O=1, STATE=0 (OFF), pwm_cnt=0, flash counter=0, synchroniser stages as above. These are reached at the first rising edge with RESET=1.
- RESET asserted mid-flash or mid-PWM returns everything to the reset values at that edge. No partial flash completes afterwards.
- Request latency: a _LED_REQ change present at edge N appears in sync2 at N+1, in STATE at N+2 and on _O at N+3.
- ENABLE is not synchronised. ENABLE=0 at edge N gives STATE=OFF at N and _O=1 at N+1.
- Flash length: _O is held at 1 for exactly BLINK_CYCLES consecutive cycles after the last activity edge, then follows the request state.
- STATE and _O each update one edge after the state change that drives them; _O is registered from the state.

## Configuration
- IO_LED_DRIVER_DIM_EN defined:
  - DIM state and PWM counter are present.
  - _LED_REQ=1 selects DIM.
- IO_LED_DRIVER_DIM_EN undefined:
  - PWM counter and DIM state are removed, and DIM_DUTY is ignored.
  - _LED_REQ=1 selects OFF, so _O=1 and STATE=0.
  - Activity edges in this request-driven OFF are ignored.
  - STATE never reports 1.

## Test plan
- Reset: hold RESET for 3 cycles with ENABLE=1, _LED_REQ=0 -> _O=1 and STATE=0 during reset. After release, STATE=2 at release+2 and _O=0 at release+3.
- Dim duty: DIM_EN defined, PWM_BITS=4, DIM_DUTY=4, _LED_REQ=1, ENABLE=1 -> _O=0 for exactly 4 of every 16 cycles, periodic. Repeat with DIM_DUTY=0 (always 1) and DIM_DUTY=16 (always 0).
- Flash: BLINK_CYCLES=16, state ON, one ACT 0->1 pulse -> STATE=3 and _O=1 for exactly 16 cycles, then STATE=2 and _O=0.
- Retrigger: a second ACT edge 10 cycles into a flash -> _O stays 1 for a total of 26 cycles.
- ENABLE abort: drop ENABLE mid-flash -> STATE=0 at that edge and _O=1 after. Raise ENABLE with no ACT activity -> request state resumes with no residual flash.
- No-DIM build: macro undefined, _LED_REQ=1, ENABLE=1, ACT pulses -> _O stays 1 and STATE stays 0 throughout.

Source files
------------

// File: rtl/io_led_driver.sv
// io_led_driver: active-low LED drive with full brightness, PWM dim and retriggerable activity flashes
// Ports: CLK clock; RESET sync active-high; ENABLE (0 forces off); _LED_REQ async active-low request
// (0 full on, 1 dim); ACT async activity level (rising edge flashes); _O registered LED (0 lit); STATE OFF/DIM/ON/BLINK.
// Define IO_LED_DRIVER_DIM_EN to build the PWM dim state; without it _LED_REQ=1 selects OFF.
module io_led_driver #(
  parameter int PWM_BITS     = 4,
  parameter int DIM_DUTY     = 4,
  parameter int BLINK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       _LED_REQ,
  input  logic       ACT,
  output logic       _O,
  output logic [1:0] STATE
);
  localparam int CW = BLINK_CYCLES > 0 ? $clog2(BLINK_CYCLES + 1) : 1;
  typedef enum logic [1:0] {OFF = 2'd0, DIM = 2'd1, ON = 2'd2, BLINK = 2'd3} state_t;
  if (DIM_DUTY < 0 || DIM_DUTY > (1 << PWM_BITS)) begin : g_bad_duty
    $error("DIM_DUTY out of range");
  end
  state_t        r_state, w_next, w_req_state;
  logic [CW-1:0] r_flash, w_flash_next;
  logic [1:0]    r_req_sync, r_act_sync;
  logic          r_act_prev, w_act_edge, w_dim_lit;
  always_ff @(posedge CLK) begin
    r_req_sync <= RESET ? 2'b11 : {r_req_sync[0], _LED_REQ};
    r_act_sync <= RESET ? 2'b00 : {r_act_sync[0], ACT};
    r_act_prev <= RESET ? 1'b0 : r_act_sync[1];
  end
  assign w_act_edge = r_act_sync[1] & ~r_act_prev;
`ifdef IO_LED_DRIVER_DIM_EN
  logic [PWM_BITS-1:0] r_pwm;
  always_ff @(posedge CLK) r_pwm <= RESET ? '0 : r_pwm + 1'b1;
  // one extra bit so DIM_DUTY = 2^PWM_BITS compares as always lit
  assign w_dim_lit   = {1'b0, r_pwm} < (PWM_BITS + 1)'(DIM_DUTY);
  assign w_req_state = r_req_sync[1] ? DIM : ON;
`else
  assign w_dim_lit   = 1'b0;
  assign w_req_state = r_req_sync[1] ? OFF : ON;
`endif
  always_comb begin
    w_next       = w_req_state;
    w_flash_next = '0;
    if (!ENABLE) begin
      w_next = OFF;
    end else if (w_act_edge && r_state != OFF && BLINK_CYCLES > 0) begin
      w_next       = BLINK;
      w_flash_next = CW'(BLINK_CYCLES);
    end else if (r_state == BLINK && r_flash > CW'(1)) begin
      w_next       = BLINK;
      w_flash_next = r_flash - 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= OFF;
      r_flash <= '0;
      _O      <= 1'b1;
    end else begin
      r_state <= w_next;
      r_flash <= w_flash_next;
      _O      <= r_state == ON ? 1'b0 : r_state == DIM ? ~w_dim_lit : 1'b1;
    end
  end
  assign STATE = r_state;
endmodule

// File: tb/tb_io_led_driver.sv
// tb_io_led_driver: randomized and directed check of io_led_driver against a flash-countdown model
module tb_io_led_driver;
  localparam int BC = 16;
`ifdef IO_LED_DRIVER_DIM_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, req = 1'b0, act = 1'b0;
  logic [2:0] o;
  logic [1:0] st [3];
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;

  io_led_driver #(.PWM_BITS(4), .DIM_DUTY(4),  .BLINK_CYCLES(BC)) u0 (.CLK(clk), .RESET(rst), .ENABLE(en), ._LED_REQ(req), .ACT(act), ._O(o[0]), .STATE(st[0]));
  io_led_driver #(.PWM_BITS(4), .DIM_DUTY(0),  .BLINK_CYCLES(BC)) u1 (.CLK(clk), .RESET(rst), .ENABLE(en), ._LED_REQ(req), .ACT(act), ._O(o[1]), .STATE(st[1]));
  io_led_driver #(.PWM_BITS(4), .DIM_DUTY(16), .BLINK_CYCLES(BC)) u2 (.CLK(clk), .RESET(rst), .ENABLE(en), ._LED_REQ(req), .ACT(act), ._O(o[2]), .STATE(st[2]));

  function automatic int duty(int i);
    return i == 0 ? 4 : i == 1 ? 0 : 16;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Model: inputs are seen through a two-edge delay (queues), a flash is a countdown of
  // remaining dark cycles, and the state is derived from enable, countdown and request.
  int m_state = 0, m_flash = 0, m_pwm = 0;
  bit m_o [3];
  bit req_q [$];
  bit act_q [$];
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0;
      m_flash = 0;
      m_pwm   = 0;
      m_o     = '{1'b1, 1'b1, 1'b1};
      req_q   = '{1'b1, 1'b1};
      act_q   = '{1'b0, 1'b0, 1'b0};
      chk_on  = 1'b1;
    end else begin
      bit act_edge;
      int req_state;
      for (int i = 0; i < 3; i++) m_o[i] = m_state == 2 ? 1'b0 : m_state == 1 ? !(m_pwm < duty(i)) : 1'b1;
      act_edge  = act_q[1] && !act_q[0];
      req_state = !req_q[0] ? 2 : DIM ? 1 : 0;
      if (!en) m_flash = 0;
      else if (act_edge && m_state != 0) m_flash = BC;
      else if (m_flash > 0) m_flash--;
      m_state = !en ? 0 : m_flash > 0 ? 3 : req_state;
      m_pwm   = (m_pwm + 1) % 16;
      void'(req_q.pop_front());
      req_q.push_back(req);
      void'(act_q.pop_front());
      act_q.push_back(act);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("state[%0d]", i), st[i], m_state);
        check($sformatf("led[%0d]", i), o[i], m_o[i]);
      end
    end
  end

  initial begin
    int c0, c1, c2, cs;
    repeat (3) @(negedge clk);
    check("reset_led", o[0], 1);
    check("reset_state", st[0], 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("release_state_on", st[0], 2);
    @(negedge clk);
    check("release_led_on", o[0], 0);
`ifdef IO_LED_DRIVER_DIM_EN
    req = 1'b1;
    repeat (8) @(negedge clk);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      c0 += (o[0] == 1'b0) ? 1 : 0;
      c1 += (o[1] == 1'b0) ? 1 : 0;
      c2 += (o[2] == 1'b0) ? 1 : 0;
    end
    check("dim4_lit_cycles", c0, 8);
    check("dim0_lit_cycles", c1, 0);
    check("dim16_lit_cycles", c2, 32);
    check("dim_state", st[0], 1);
    req = 1'b0;
`endif
    repeat (6) @(negedge clk);
    act = 1'b1;
    c0 = 0; cs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 1) act = 1'b0;
      c0 += (o[0] == 1'b1) ? 1 : 0;
      cs += (st[0] == 2'd3) ? 1 : 0;
    end
    check("flash_dark_cycles", c0, 16);
    check("flash_blink_cycles", cs, 16);
    check("flash_end_state", st[0], 2);
    check("flash_end_led", o[0], 0);
    act = 1'b1;
    c0 = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 1 || k == 11) act = 1'b0;
      if (k == 9) act = 1'b1;
      c0 += (o[0] == 1'b1) ? 1 : 0;
    end
    check("retrigger_dark_cycles", c0, 26);
    act = 1'b1;
    repeat (2) @(negedge clk);
    act = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre_state", st[0], 3);
    en = 1'b0;
    @(negedge clk);
    check("abort_state", st[0], 0);
    @(negedge clk);
    check("abort_led", o[0], 1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("resume_state", st[0], 2);
    check("resume_led", o[0], 0);
    cs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cs += (st[0] == 2'd3) ? 1 : 0;
    end
    check("resume_no_flash", cs, 0);
`ifndef IO_LED_DRIVER_DIM_EN
    req = 1'b1;
    repeat (4) @(negedge clk);
    cs = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k % 5 == 0) act = ~act;
      cs += (o[0] != 1'b1 || st[0] != 2'd0) ? 1 : 0;
    end
    check("nodim_off_cycles_lit", cs, 0);
    act = 1'b0;
`endif
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if (en ? $urandom_range(0, 79) == 0 : $urandom_range(0, 4) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) req = ~req;
      if ($urandom_range(0, 14) == 0) act = ~act;
    end
    rst = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
